// File: rtl/mips_multicycle_if.sv
// Unified instruction/data memory port with a ready handshake.
// The core is the master; it holds a request until the cycle that has mem_ready=1.
interface mips_multicycle_if;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_writedata,
    input  mem_readdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_writedata,
    output mem_readdata, mem_ready
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core (add/sub/and/or/slt/addi/lw/sw/beq/j).
// One shared memory port with wait states; unknown encodings halt in TRAP until reset.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          REG_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mips_multicycle_if.master mem,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25, F_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic        active_q;
  logic [31:0] rf_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, rf_waddr;
  logic [31:0] imm_sext, rs_val, rt_val, alu_r, rf_wdata;
  logic        legal, rf_we;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign legal    = ((op == OP_RTYPE) && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}))
                 || (op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});

  always_comb begin
    case (funct)
      F_ADD:   alu_r = a_q + b_q;
      F_SUB:   alu_r = a_q - b_q;
      F_AND:   alu_r = a_q & b_q;
      F_OR:    alu_r = a_q | b_q;
      F_SLT:   alu_r = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
      default: alu_r = 32'd0;
    endcase
  end

  // Bus outputs decode registered state only; active_q keeps the port quiet
  // for the first cycle after reset so a reset mid-access drops mem_req at once.
  assign mem.mem_req       = active_q && ((state_q == FETCH) || (state_q == MEM));
  assign mem.mem_wr        = (state_q == MEM) && (op == OP_SW);
  assign mem.mem_addr      = (state_q == MEM) ? alu_q : pc_q;
  assign mem.mem_writedata = b_q;
  assign pc                = pc_q;
  assign halted            = (state_q == TRAP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = (op == OP_RTYPE) ? rd : rt;
    rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
    case (state_q)
      FETCH: begin
        if (active_q && mem.mem_ready) begin
          ir_d    = mem.mem_readdata;
          npc_d   = pc_q + 32'd4;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        alu_d   = npc_q + {imm_sext[29:0], 2'b00};
        state_d = legal ? EXEC : TRAP;
      end
      EXEC: begin
        case (op)
          OP_RTYPE: begin alu_d = alu_r;          state_d = WB;  end
          OP_ADDI:  begin alu_d = a_q + imm_sext; state_d = WB;  end
          OP_LW,
          OP_SW:    begin alu_d = a_q + imm_sext; state_d = MEM; end
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? alu_q : npc_q;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_J: begin
            pc_d    = {npc_q[31:28], ir_q[25:0], 2'b00};
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        if (mem.mem_ready) begin
          if (op == OP_SW) begin
            pc_d    = npc_q;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_d   = mem.mem_readdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = (rf_waddr != 5'd0);
        pc_d    = npc_q;
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      active_q <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (reset) begin
        if (REG_CLEAR) rf_q[gi] <= '0;
      end else if (rf_we && (rf_waddr == 5'(gi))) begin
        rf_q[gi] <= rf_wdata;
      end
    end
  end
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed program bench for mips_multicycle: a wait-state memory model feeds the core,
// and two monitors compare completed bus transactions and retire pulses against queues.
module tb_mips_multicycle;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        retire, halted;

  always #5 clk = ~clk;

  mips_multicycle_if bus ();

  mips_multicycle #(.RESET_PC(32'h0000_0000), .REG_CLEAR(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (bus.master),
    .pc     (pc),
    .retire (retire),
    .halted (halted)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct { logic [31:0] pc; int cycles; } ret_t;

  txn_t        exp_q[$];
  ret_t        ret_q[$];
  logic [31:0] mem [256];
  int          waits = 0;
  int          checks = 0;
  int          errors = 0;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic push_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back('{wr, addr, data});
  endtask

  // Load one instruction and queue its fetch and its retire latency for the current wait setting.
  task automatic put(input logic [31:0] a, input logic [31:0] word, input int base, input int accesses);
    mem[a[9:2]] = word;
    push_txn(1'b0, a, 32'd0);
    ret_q.push_back('{a, base + waits * accesses});
  endtask

  // Memory model: answers after `waits` stall cycles; writes commit on the completing edge.
  initial begin
    logic        r, pend, pend_wr;
    logic [31:0] pend_addr, pend_data;
    int          cnt;
    pend = 1'b0; pend_wr = 1'b0; pend_addr = '0; pend_data = '0; cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(posedge clk);
      r = reset;
      #1;
      if (pend && !r && pend_wr) mem[pend_addr[9:2]] = pend_data;
      pend = 1'b0;
      if (reset || !bus.mem_req) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (cnt >= waits) begin
        bus.mem_ready    = 1'b1;
        bus.mem_readdata = mem[bus.mem_addr[9:2]];
        pend      = 1'b1;
        pend_wr   = bus.mem_wr;
        pend_addr = bus.mem_addr;
        pend_data = bus.mem_writedata;
        cnt = 0;
      end else begin
        bus.mem_ready = 1'b0;
        cnt++;
      end
    end
  end

  // Transaction monitor
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_req && bus.mem_ready) begin
        $display("txn wr=%0b addr=%h wdata=%h", bus.mem_wr, bus.mem_addr, bus.mem_writedata);
        if (exp_q.size() == 0) begin
          check32("txn_unexpected_addr", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          t = exp_q.pop_front();
          check32("txn_wr", 32'(bus.mem_wr), 32'(t.wr));
          check32("txn_addr", bus.mem_addr, t.addr);
          if (t.wr) check32("txn_wdata", bus.mem_writedata, t.data);
        end
      end
    end
  end

  // Retire monitor: cycles counted from the first cycle of each instruction
  initial begin
    ret_t r;
    int   cnt;
    logic started;
    cnt = 0; started = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        started = 1'b0;
      end else begin
        if (bus.mem_req) started = 1'b1;
        if (started) cnt++;
        if (retire) begin
          $display("retire pc=%h cycles=%0d", pc, cnt);
          if (ret_q.size() == 0) begin
            check32("retire_unexpected_pc", pc, 32'hFFFF_FFFF);
          end else begin
            r = ret_q.pop_front();
            check32("retire_pc", pc, r.pc);
            check32("retire_cycles", 32'(cnt), 32'(r.cycles));
          end
          cnt = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, reqs, i;
    int          sw_regs [7];
    logic [31:0] sw_vals [7];
    sw_regs = '{4, 5, 6, 7, 8, 9, 0};
    sw_vals = '{32'd1, 32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0};
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;

    // Program 1, zero wait states
    waits = 0;
    put(32'h00, enc_i(6'h08, 0, 1, 16'd5), 4, 1);
    put(32'h04, enc_i(6'h08, 0, 2, 16'hFFFD), 4, 1);
    put(32'h08, enc_r(1, 2, 3, 6'h20), 4, 1);
    put(32'h0C, enc_r(2, 1, 4, 6'h2A), 4, 1);
    put(32'h10, enc_i(6'h04, 1, 1, 16'd3), 3, 1);
    mem[32'h14 >> 2] = ILLEGAL;
    put(32'h20, enc_i(6'h04, 1, 2, 16'd3), 3, 1);
    put(32'h24, enc_i(6'h2B, 0, 3, 16'h0200), 4, 2);
    push_txn(1'b1, 32'h200, 32'd2);
    put(32'h28, enc_r(1, 2, 6, 6'h22), 4, 1);
    put(32'h2C, enc_r(1, 2, 7, 6'h24), 4, 1);
    put(32'h30, enc_r(1, 2, 8, 6'h25), 4, 1);
    put(32'h34, enc_r(1, 2, 9, 6'h2A), 4, 1);
    put(32'h38, enc_i(6'h08, 0, 0, 16'd7), 4, 1);
    put(32'h3C, enc_i(6'h23, 0, 5, 16'h0200), 5, 2);
    push_txn(1'b0, 32'h200, 32'd0);
    for (int k = 0; k < 7; k++) begin
      put(32'h40 + 32'(4 * k), enc_i(6'h2B, 0, sw_regs[k], 16'(32'h204 + 4 * k)), 4, 2);
      push_txn(1'b1, 32'h204 + 32'(4 * k), sw_vals[k]);
    end
    put(32'h5C, enc_j(26'h40), 3, 1);
    mem[32'h100 >> 2] = ILLEGAL;
    push_txn(1'b0, 32'h100, 32'd0);

    repeat (3) @(negedge clk);
    check32("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check32("reset_halted", 32'(halted), 32'd0);
    check32("reset_retire", 32'(retire), 32'd0);
    check32("reset_pc", pc, 32'd0);

    @(posedge clk); #2 reset = 1'b0;
    for (i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
    check32("first_fetch_seen", 32'(bus.mem_req), 32'd1);
    check32("first_fetch_addr", bus.mem_addr, 32'd0);
    check32("first_fetch_pc", pc, 32'd0);

    for (i = 0; i < 1000 && !halted; i++) @(negedge clk);
    check32("trap_halted", 32'(halted), 32'd1);
    check32("trap_pc", pc, 32'h100);
    reqs = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_req) reqs++;
    end
    check32("trap_no_req", 32'(reqs), 32'd0);
    check32("trap_pc_frozen", pc, 32'h100);
    check32("p1_txn_left", 32'(exp_q.size()), 32'd0);
    check32("p1_retire_left", 32'(ret_q.size()), 32'd0);

    // Reset out of TRAP
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check32("trap_reset_halted", 32'(halted), 32'd0);
    check32("trap_reset_pc", pc, 32'd0);
    check32("trap_reset_req", 32'(bus.mem_req), 32'd0);

    // Program 2, two wait states per access
    waits = 2;
    put(32'h00, enc_i(6'h08, 0, 3, 16'd2), 4, 1);
    put(32'h04, enc_i(6'h2B, 0, 3, 16'h0300), 4, 2);
    push_txn(1'b1, 32'h300, 32'd2);
    put(32'h08, enc_i(6'h23, 0, 5, 16'h0300), 5, 2);
    push_txn(1'b0, 32'h300, 32'd0);
    put(32'h0C, enc_i(6'h2B, 0, 5, 16'h0304), 4, 2);
    push_txn(1'b1, 32'h304, 32'd2);
    mem[32'h10 >> 2] = enc_j(26'h0);
    @(posedge clk); #2 reset = 1'b0;

    for (i = 0; i < 200 && !(bus.mem_req && bus.mem_wr); i++) @(negedge clk);
    check32("sw_seen", 32'(bus.mem_req && bus.mem_wr), 32'd1);
    n = 0;
    while (bus.mem_req && bus.mem_wr && n < 20) begin
      check32("sw_hold_addr", bus.mem_addr, 32'h300);
      check32("sw_hold_data", bus.mem_writedata, 32'd2);
      n++;
      @(negedge clk);
    end
    check32("sw_hold_cycles", 32'(n), 32'd3);

    // Reset in the middle of a stalled fetch
    for (i = 0; i < 200 && !(bus.mem_req && !bus.mem_ready && bus.mem_addr == 32'h10); i++) @(negedge clk);
    check32("stall_fetch_seen", 32'(bus.mem_req && !bus.mem_ready), 32'd1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check32("midreset_req", 32'(bus.mem_req), 32'd0);
    check32("midreset_wr", 32'(bus.mem_wr), 32'd0);
    check32("midreset_pc", pc, 32'd0);
    check32("p2_txn_left", 32'(exp_q.size()), 32'd0);
    check32("p2_retire_left", 32'(ret_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
